// File: rtl/byte_ram_responder_pkg.sv
// Shared constants and types for the byte-serial RAM responder.
// Provides IO window decode constants, flag levels and the access-history bundle.
package byte_ram_responder_pkg;

    // Address bit that selects the IO window instead of RAM.
    localparam int IO_BIT = 17;

    // IO window register offsets (mem_a[2:0]).
    localparam logic [2:0] IO_DATA_OFF   = 3'd0;
    localparam logic [2:0] IO_STATUS_OFF = 3'd4;

    localparam logic [7:0] ZERO_WORD = 8'h00;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    // Snapshot of one bus cycle, used to detect the first cycle of an access.
    typedef struct packed {
        logic [17:0] addr;
        logic        wr;
        logic        hit;
    } acc_hist_t;

    // A DATA access starts when it hits now and either the last cycle
    // missed or the address/direction changed.
    function automatic logic is_start(acc_hist_t prev, acc_hist_t cur);
        return cur.hit && (!prev.hit ||
                           (prev.addr != cur.addr) ||
                           (prev.wr != cur.wr));
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with 2**FIFO_AW entries and wrap-bit pointers.
// Ports: clk, rst (sync, active-low), push_i/din_i, pop_i, dout_o (head), empty_o, full_o.
module byte_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [FIFO_AW:0] wptr_q, wptr_d;
    logic [FIFO_AW:0] rptr_q, rptr_d;
    logic [7:0]       mem_q [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

    // A pop on empty is ignored; a push on full is accepted only when
    // a pop frees the head slot on the same edge.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign dout_o = mem_q[rptr_q[FIFO_AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_ok) mem_q[wptr_q[FIFO_AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/byte_ram_responder.sv
// Memory-side responder: byte RAM plus IO window with TX/RX byte FIFOs.
// Ports: clk, rst (sync, active-low); bus mem_a/mem_wr/ram_din/ram_dout;
//   TX stream tx_valid/tx_data/tx_ready; RX stream rx_valid/rx_data/rx_ready;
//   sticky tx_ovf; prot_err only when BYTE_RAM_PROTECT_EN is defined.
module byte_ram_responder
    import byte_ram_responder_pkg::*;
#(
    parameter int          RAM_AW      = 17,
    parameter int          FIFO_AW     = 4,
    parameter logic [31:0] PROTECT_TOP = 32'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
`ifdef BYTE_RAM_PROTECT_EN
    output logic        prot_err,
`endif
    output logic        tx_ovf
);

    logic [7:0]  ram_q [2**RAM_AW];
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        tx_ovf_q, tx_ovf_d;
    acc_hist_t   hist_q, hist_d;

    logic        io_sel;
    logic        data_hit;
    logic        stat_hit;
    logic        start;
    logic        ram_wr;
    logic        ram_we;
    logic [RAM_AW-1:0] ram_idx;

    logic        tx_push, tx_pop, tx_empty, tx_full;
    logic        rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]  rx_head;

    assign io_sel   = mem_a[IO_BIT];
    assign data_hit = io_sel && (mem_a[2:0] == IO_DATA_OFF);
    assign stat_hit = io_sel && (mem_a[2:0] == IO_STATUS_OFF);
    assign ram_idx  = mem_a[RAM_AW-1:0];
    assign ram_wr   = mem_wr && !io_sel;

    assign hist_d = '{addr: mem_a[17:0], wr: mem_wr, hit: data_hit};
    assign start  = is_start(hist_q, hist_d);

    assign tx_push = start && mem_wr;
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_pop  = start && !mem_wr;
    assign rx_push = rx_valid && rx_ready;

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;
    assign ram_dout = ram_dout_q;
    assign tx_ovf   = tx_ovf_q;

`ifdef BYTE_RAM_PROTECT_EN
    logic prot_hit;
    logic prot_err_q, prot_err_d;

    assign prot_hit   = ({14'b0, mem_a[17:0]} < PROTECT_TOP);
    assign ram_we     = rst && ram_wr && !prot_hit;
    assign prot_err_d = prot_err_q || (ram_wr && prot_hit);
    assign prot_err   = prot_err_q;

    always_ff @(posedge clk) begin
        if (!rst) prot_err_q <= DISABLED;
        else      prot_err_q <= prot_err_d;
    end

    logic unused_bits;
    assign unused_bits = ^mem_a[31:18];
`else
    assign ram_we = rst && ram_wr;

    logic unused_bits;
    assign unused_bits = ^{mem_a[31:18], PROTECT_TOP};
`endif

    // Dropped TX byte: start of a DATA write while full with no pop freeing a slot.
    assign tx_ovf_d = tx_ovf_q || (tx_push && tx_full && !tx_pop);

    always_comb begin
        ram_dout_d = ram_dout_q;
        if (!mem_wr) begin
            unique case (1'b1)
                !io_sel: ram_dout_d = ram_q[ram_idx];
                data_hit: begin
                    // Non-start cycles of a held access repeat the last byte.
                    if (start) ram_dout_d = rx_empty ? ZERO_WORD : rx_head;
                end
                stat_hit: ram_dout_d = {6'b0, !rx_empty, tx_full};
                default:  ram_dout_d = ZERO_WORD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_dout_q <= ZERO_WORD;
            tx_ovf_q   <= DISABLED;
            hist_q     <= '0;
        end else begin
            ram_dout_q <= ram_dout_d;
            tx_ovf_q   <= tx_ovf_d;
            hist_q     <= hist_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= ram_din;
    end

    byte_fifo #(.FIFO_AW(FIFO_AW)) u_tx (
        .clk    (clk),
        .rst    (rst),
        .push_i (tx_push),
        .din_i  (ram_din),
        .pop_i  (tx_pop),
        .dout_o (tx_data),
        .empty_o(tx_empty),
        .full_o (tx_full)
    );

    byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx (
        .clk    (clk),
        .rst    (rst),
        .push_i (rx_push),
        .din_i  (rx_data),
        .pop_i  (rx_pop),
        .dout_o (rx_head),
        .empty_o(rx_empty),
        .full_o (rx_full)
    );

endmodule

// File: tb/tb_byte_ram_responder.sv
// Testbench for byte_ram_responder: RAM, RX/TX windows, overflow, reset.
// Protection checks compile in when BYTE_RAM_PROTECT_EN is defined.
module tb_byte_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_ovf;
`ifdef BYTE_RAM_PROTECT_EN
    logic        prot_err;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] txexp_q[$];

    always #5 clk = ~clk;

    byte_ram_responder dut (
        .clk     (clk),
        .rst     (rst),
        .mem_a   (mem_a),
        .mem_wr  (mem_wr),
        .ram_din (ram_din),
        .ram_dout(ram_dout),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ready(rx_ready),
`ifdef BYTE_RAM_PROTECT_EN
        .prot_err(prot_err),
`endif
        .tx_ovf  (tx_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a read, expect 'e' on ram_dout one edge later.
    task automatic rd(input logic [31:0] a, input logic [7:0] e, input string nm);
        logic [7:0] x;
        mem_a = a;
        mem_wr = 1'b0;
        exp_q.push_back(e);
        tick();
        x = exp_q.pop_front();
        total_cnt++;
        if (ram_dout !== x)
            $display("FAIL %s: ram_dout=%h expected %h", nm, ram_dout, x);
        else pass_cnt++;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        mem_a = a;
        mem_wr = 1'b1;
        ram_din = d;
        tick();
        mem_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (ram_dout !== 8'h00) $display("FAIL rst_dout: %h expected 00", ram_dout);
        else pass_cnt++;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL rst_txv: %b expected 0", tx_valid);
        else pass_cnt++;
        total_cnt++;
        if (rx_ready !== 1'b1) $display("FAIL rst_rxr: %b expected 1", rx_ready);
        else pass_cnt++;
        total_cnt++;
        if (tx_ovf !== 1'b0) $display("FAIL rst_ovf: %b expected 0", tx_ovf);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_ram();
        logic [7:0] v [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        for (int i = 0; i < 4; i++) wr(32'h100 + i, v[i]);
        for (int i = 0; i < 4; i++) rd(32'h100 + i, v[i], "ram_rd");
        // Write cycle holds the previous read byte.
        mem_a = 32'h200;
        mem_wr = 1'b1;
        ram_din = 8'h99;
        tick();
        mem_wr = 1'b0;
        total_cnt++;
        if (ram_dout !== 8'h78) $display("FAIL wr_hold: %h expected 78", ram_dout);
        else pass_cnt++;
        rd(32'h200, 8'h99, "ram_rd2");
        // Upper address bits are ignored.
        rd(32'hABC0_0101, 8'h34, "ram_alias");
    endtask

    task automatic test_rx_hold();
        mem_a = 32'h100;
        mem_wr = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'hA5;
        tick();
        rx_data = 8'h5A;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) rd(32'h30000, 8'hA5, "rx_hold");
        rd(32'h30004, 8'h02, "stat_rx1");
        rd(32'h30000, 8'h5A, "rx_second");
        rd(32'h30004, 8'h00, "stat_rx0");
        rd(32'h30000, 8'h00, "rx_empty");
        rd(32'h30001, 8'h00, "io_other");
    endtask

    task automatic test_tx_overflow();
        int guard;
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr(32'h30000, 8'h40 + 8'(i));
            if (i < 16) txexp_q.push_back(8'h40 + 8'(i));
            mem_a = 32'h100;
            tick();
        end
        total_cnt++;
        if (tx_ovf !== 1'b1) $display("FAIL tx_ovf: %b expected 1", tx_ovf);
        else pass_cnt++;
        rd(32'h30004, 8'h01, "stat_full");
        total_cnt++;
        if (tx_valid !== 1'b1) $display("FAIL tx_valid: %b expected 1", tx_valid);
        else pass_cnt++;
        tx_ready = 1'b1;
        guard = 0;
        while (txexp_q.size() > 0 && guard < 40) begin
            if (tx_valid) begin
                logic [7:0] e;
                e = txexp_q.pop_front();
                total_cnt++;
                if (tx_data !== e)
                    $display("FAIL tx_drain: tx_data=%h expected %h", tx_data, e);
                else pass_cnt++;
            end
            tick();
            guard++;
        end
        if (txexp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL tx_timeout: %0d left expected 0", txexp_q.size());
            txexp_q.delete();
        end
        tx_ready = 1'b0;
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL tx_empty: %b expected 0", tx_valid);
        else pass_cnt++;
        total_cnt++;
        if (tx_ovf !== 1'b1) $display("FAIL tx_sticky: %b expected 1", tx_ovf);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        rd(32'h100, 8'h12, "b2b_pre");
        rx_valid = 1'b1;
        rx_data = 8'hC3;
        rd(32'h30000, 8'h00, "rx_same_cyc");
        rx_valid = 1'b0;
        rd(32'h100, 8'h12, "b2b_brk");
        rd(32'h30000, 8'hC3, "rx_landed");
    endtask

    task automatic test_reset_mid();
        mem_a = 32'h100;
        rx_valid = 1'b1;
        rx_data = 8'h11;
        tick();
        rx_data = 8'h22;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(32'h30000, 8'h60 + 8'(i));
            mem_a = 32'h100;
            tick();
        end
        rd(32'h30000, 8'h11, "mid_pop");
        rst = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL mid_txv: %b expected 0", tx_valid);
        else pass_cnt++;
        total_cnt++;
        if (ram_dout !== 8'h00) $display("FAIL mid_dout: %h expected 00", ram_dout);
        else pass_cnt++;
        total_cnt++;
        if (tx_ovf !== 1'b0) $display("FAIL mid_ovf: %b expected 0", tx_ovf);
        else pass_cnt++;
        total_cnt++;
        if (rx_ready !== 1'b1) $display("FAIL mid_rxr: %b expected 1", rx_ready);
        else pass_cnt++;
        rst = 1'b1;
        rd(32'h30004, 8'h00, "mid_stat");
        rd(32'h30000, 8'h00, "mid_rx_empty");
        rd(32'h100, 8'h12, "mid_ram_kept");
    endtask

`ifdef BYTE_RAM_PROTECT_EN
    task automatic test_protect();
        logic [7:0] base;
        total_cnt++;
        if (prot_err !== 1'b0) $display("FAIL prot_init: %b expected 0", prot_err);
        else pass_cnt++;
        mem_a = 32'h800;
        mem_wr = 1'b0;
        tick();
        base = ram_dout;
        wr(32'h800, ~base);
        total_cnt++;
        if (prot_err !== 1'b1) $display("FAIL prot_err: %b expected 1", prot_err);
        else pass_cnt++;
        rd(32'h800, base, "prot_keep");
        wr(32'h1000, 8'h3C);
        rd(32'h1000, 8'h3C, "prot_open");
    endtask
`endif

    initial begin
        rst = 1'b0;
        mem_a = '0;
        mem_wr = 1'b0;
        ram_din = '0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        test_reset();
        test_ram();
        test_rx_hold();
        test_tx_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef BYTE_RAM_PROTECT_EN
        test_protect();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
